// File: rtl/image_write_ctrl.sv
// rtl/image_write_ctrl.sv - frame scheduler feeding RGB pixel pairs to the BMP image writer
//
// Purpose: buffers upstream pixel pairs in a small FIFO and emits them to the
// image writer one pair per cycle. It inserts HBLANK idle cycles after every
// row except the last, and pulses frame_done once after the final pair.
//
// Ports:
//   HCLK, HRESET         clock, synchronous active-high reset
//   start                one-cycle frame request, honoured only when idle
//   in_valid/in_ready    upstream handshake for in_pixels {R0,G0,B0,R1,G1,B1}
//   hsync, DATA_WRITE_*  write strobe and registered pair to the image writer
//   busy                 frame in progress (held through the frame_done cycle)
//   row, col             position of the next pair to be emitted
//   frame_done           one-cycle pulse following the last pair's hsync
module image_write_ctrl #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int HBLANK     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [47:0]                  in_pixels,
  output logic                         hsync,
  output logic [7:0]                   DATA_WRITE_R0,
  output logic [7:0]                   DATA_WRITE_G0,
  output logic [7:0]                   DATA_WRITE_B0,
  output logic [7:0]                   DATA_WRITE_R1,
  output logic [7:0]                   DATA_WRITE_G1,
  output logic [7:0]                   DATA_WRITE_B1,
  output logic                         busy,
  output logic [$clog2(HEIGHT)-1:0]    row,
  output logic [$clog2(WIDTH/2)-1:0]   col,
  output logic                         frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT / 2;
  localparam int RW    = $clog2(HEIGHT);
  localparam int CW    = $clog2(WIDTH / 2);
  localparam int NW    = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = (HBLANK > 2) ? $clog2(HBLANK) : 1;

  localparam logic [NW-1:0] TOTAL_C    = NW'(TOTAL);
  localparam logic [NW-1:0] LAST_PAIR  = NW'(TOTAL - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH / 2 - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BLANK_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_BLANK,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [47:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic [NW-1:0]   r_acc;
  logic [NW-1:0]   r_emit;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [BW-1:0]   r_blank;

  logic            r_hsync;
  logic [47:0]     r_data;
  logic            r_frame_done;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_ready;

  assign w_full  = (r_count == FIFO_FULL);
  assign w_empty = (r_count == '0);
  // Full flag is taken from registered occupancy, so a full FIFO never
  // accepts even when it is being popped in the same cycle.
  assign w_ready = ((r_state == S_ACTIVE) || (r_state == S_BLANK)) &&
                   !w_full && (r_acc < TOTAL_C);
  assign w_push  = in_valid && w_ready;
  assign w_pop   = (r_state == S_ACTIVE) && !w_empty;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_pop && (r_emit == LAST_PAIR)) begin
          w_next = S_DONE;
        end else if (w_pop && (r_col == COL_LAST) && (HBLANK > 0)) begin
          w_next = S_BLANK;
        end
      end
      S_BLANK: begin
        if (r_blank == BLANK_LAST) w_next = S_ACTIVE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= in_pixels;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_acc        <= '0;
      r_emit       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_blank      <= '0;
      r_hsync      <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_hsync      <= w_pop;
      r_frame_done <= (r_state == S_DONE);

      if (w_pop) r_data <= r_mem[r_rd_ptr];

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase

      if (r_state == S_BLANK) r_blank <= r_blank + BW'(1);
      else                    r_blank <= '0;

      if (r_state == S_IDLE) begin
        r_acc  <= '0;
        r_emit <= '0;
        r_row  <= '0;
        r_col  <= '0;
      end else begin
        if (w_push) r_acc <= r_acc + NW'(1);
        if (w_pop) begin
          r_emit <= r_emit + NW'(1);
          if (r_col == COL_LAST) begin
            r_col <= '0;
            // Row stays on the last row once the frame's final pair leaves.
            if (r_emit != LAST_PAIR) r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
      end
    end
  end

  assign in_ready      = w_ready;
  assign hsync         = r_hsync;
  assign DATA_WRITE_R0 = r_data[47:40];
  assign DATA_WRITE_G0 = r_data[39:32];
  assign DATA_WRITE_B0 = r_data[31:24];
  assign DATA_WRITE_R1 = r_data[23:16];
  assign DATA_WRITE_G1 = r_data[15:8];
  assign DATA_WRITE_B1 = r_data[7:0];
  // busy covers the frame_done cycle, which the state machine spends in IDLE.
  assign busy          = (r_state != S_IDLE) || r_frame_done;
  assign row           = r_row;
  assign col           = r_col;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_image_write_ctrl.sv
// tb/tb_image_write_ctrl.sv - self-checking bench for image_write_ctrl
module tb_image_write_ctrl;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int DEPTH = 4;
  localparam int RL    = W / 2;
  localparam int TOTAL = W * H / 2;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic        a_start, a_valid, a_ready, a_hsync, a_busy, a_fd;
  logic [47:0] a_pix;
  logic [7:0]  a_r0, a_g0, a_b0, a_r1, a_g1, a_b1;
  logic [1:0]  a_row, a_col;
  logic        b_start, b_valid, b_ready, b_hsync, b_busy, b_fd;
  logic [47:0] b_pix;
  logic [7:0]  b_r0, b_g0, b_b0, b_r1, b_g1, b_b1;
  logic [1:0]  b_row, b_col;

  image_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .start(a_start), .in_valid(a_valid),
    .in_ready(a_ready), .in_pixels(a_pix), .hsync(a_hsync),
    .DATA_WRITE_R0(a_r0), .DATA_WRITE_G0(a_g0), .DATA_WRITE_B0(a_b0),
    .DATA_WRITE_R1(a_r1), .DATA_WRITE_G1(a_g1), .DATA_WRITE_B1(a_b1),
    .busy(a_busy), .row(a_row), .col(a_col), .frame_done(a_fd)
  );

  image_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .start(b_start), .in_valid(b_valid),
    .in_ready(b_ready), .in_pixels(b_pix), .hsync(b_hsync),
    .DATA_WRITE_R0(b_r0), .DATA_WRITE_G0(b_g0), .DATA_WRITE_B0(b_b0),
    .DATA_WRITE_R1(b_r1), .DATA_WRITE_G1(b_g1), .DATA_WRITE_B1(b_b1),
    .busy(b_busy), .row(b_row), .col(b_col), .frame_done(b_fd)
  );

  typedef struct {
    logic        hsync, in_ready, busy, frame_done;
    logic [1:0]  row, col;
    logic [47:0] data;
  } obs_t;

  typedef struct {
    logic rst, st, vld;
    logic busy, rdy, hs;
    logic [1:0] row, col;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] pat(input int i);
    logic [47:0] p;
    for (int k = 0; k < 6; k++) p[47 - 8 * k -: 8] = 8'(i * 6 + k + 1);
    return p;
  endfunction

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.hsync = a_hsync; o.in_ready = a_ready; o.busy = a_busy; o.frame_done = a_fd;
      o.row = a_row; o.col = a_col; o.data = {a_r0, a_g0, a_b0, a_r1, a_g1, a_b1};
    end else begin
      o.hsync = b_hsync; o.in_ready = b_ready; o.busy = b_busy; o.frame_done = b_fd;
      o.row = b_row; o.col = b_col; o.data = {b_r0, b_g0, b_b0, b_r1, b_g1, b_b1};
    end
    return o;
  endfunction

  task automatic drive(input int sel, input logic st, input logic vld, input logic [47:0] pix);
    a_start = (sel == 0) ? st : 1'b0;
    a_valid = (sel == 0) ? vld : 1'b0;
    a_pix   = (sel == 0) ? pix : '0;
    b_start = (sel == 1) ? st : 1'b0;
    b_valid = (sel == 1) ? vld : 1'b0;
    b_pix   = (sel == 1) ? pix : '0;
  endtask

  // mode: 0 continuous, 1 toggling valid, 2 random valid/data,
  //       3 continuous with start re-pulsed, 4 reset after 6th beat
  task automatic run_frame(input int sel, input int mode, input int hblank);
    logic [47:0] q[$];
    logic [47:0] nxt, prev_data, rnd;
    obs_t o;
    int   acc, beats, occ, cyc, last_beat, first_acc, gap, tail;
    bit   in_frame, prev_push, fd_due, done, saw_full, vld, exact, st;
    acc = 0; beats = 0; cyc = 0; last_beat = -1; first_acc = -1; tail = 0;
    in_frame = 0; prev_push = 0; fd_due = 0; done = 0; saw_full = 0;
    prev_data = '0;
    rnd = {$urandom, $urandom};
    exact = (mode == 0 || mode == 3);

    drive(sel, 1'b1, 1'b0, '0);
    @(posedge HCLK); #1;
    in_frame = 1;

    while (!done && cyc < 400) begin
      o = get_obs(sel);
      if (prev_push) begin
        q.push_back(prev_data);
        acc++;
        rnd = {$urandom, $urandom};
      end
      if (o.hsync) begin
        chk("beat_has_data", q.size() > 0, 1);
        if (q.size() > 0) chk("data", o.data, q.pop_front());
        if (last_beat >= 0) begin
          gap = cyc - last_beat - 1;
          if (beats % RL == 0) begin
            if (exact) chk("row_gap", gap, hblank);
            else       chk("row_gap_min", gap >= hblank, 1);
          end else if (exact) begin
            chk("mid_row_gap", gap, 0);
          end
        end else if (mode == 0) begin
          chk("latency", cyc - first_acc, 2);
        end
        beats++;
        last_beat = cyc;
      end
      occ = acc - beats;
      chk("frame_done", o.frame_done, fd_due);
      chk("busy", o.busy, in_frame || fd_due);
      if (in_frame) begin
        chk("row", o.row, (beats == TOTAL) ? H - 1 : beats / RL);
        chk("col", o.col, (beats == TOTAL) ? 0 : beats % RL);
      end
      chk("in_ready", o.in_ready,
          in_frame && beats < TOTAL && occ < DEPTH && acc < TOTAL);
      if (occ == DEPTH && !o.in_ready) saw_full = 1;

      if (fd_due) begin
        fd_due = 0;
        tail = 1;
      end else if (tail > 0) begin
        tail++;
        if (tail > 3) done = 1;
      end
      if (in_frame && beats == TOTAL) begin
        in_frame = 0;
        fd_due = 1;
      end

      if (mode == 4 && beats == 6 && in_frame) begin
        HRESET = 1'b1;
        drive(sel, 1'b0, 1'b0, '0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        o = get_obs(sel);
        chk("rst_hsync", o.hsync, 0);
        chk("rst_ready", o.in_ready, 0);
        chk("rst_busy", o.busy, 0);
        chk("rst_fd", o.frame_done, 0);
        chk("rst_rowcol", {o.row, o.col}, 0);
        chk("rst_data", o.data, 0);
        for (int k = 0; k < 3; k++) begin
          @(posedge HCLK); #1;
          o = get_obs(sel);
          chk("rst_no_fd", o.frame_done, 0);
          chk("rst_idle_busy", o.busy, 0);
        end
        drive(sel, 1'b0, 1'b0, '0);
        return;
      end

      case (mode)
        1:       vld = (cyc % 2 == 0);
        2:       vld = 1'($urandom_range(0, 1));
        default: vld = 1;
      endcase
      nxt = (mode == 2) ? rnd : pat(acc + 100 * mode);
      st  = (mode == 3) && in_frame && (cyc % 5 == 2);
      drive(sel, st, vld, nxt);
      prev_push = vld && o.in_ready;
      prev_data = nxt;
      if (prev_push && first_acc < 0) first_acc = cyc;
      @(posedge HCLK); #1;
      cyc++;
    end
    chk("frame_completed", done, 1);
    chk("beats_total", beats, TOTAL);
    if (hblank > 0 && exact) chk("backpressure_full", saw_full, 1);
    drive(sel, 1'b0, 1'b0, '0);
  endtask

  vec_t vecs[12];

  initial begin
    // rst st vld | busy rdy hs row col
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 1, 1, 0, 1};
    vecs[5]  = '{0, 0, 1, 1, 1, 1, 0, 2};
    vecs[6]  = '{0, 0, 1, 1, 1, 1, 0, 3};
    vecs[7]  = '{0, 0, 1, 1, 1, 1, 1, 0};
    vecs[8]  = '{0, 0, 1, 1, 1, 0, 1, 0};
    vecs[9]  = '{0, 0, 1, 1, 1, 0, 1, 0};
    vecs[10] = '{0, 0, 1, 1, 1, 1, 1, 1};
    vecs[11] = '{1, 0, 1, 0, 0, 0, 0, 0};

    HRESET = 1'b1;
    drive(0, 1'b0, 1'b0, '0);
    @(posedge HCLK); #1;

    for (int i = 0; i < 12; i++) begin
      obs_t o;
      HRESET = vecs[i].rst;
      drive(0, vecs[i].st, vecs[i].vld, pat(i));
      @(posedge HCLK); #1;
      o = get_obs(0);
      chk($sformatf("tbl%0d_busy", i), o.busy, vecs[i].busy);
      chk($sformatf("tbl%0d_ready", i), o.in_ready, vecs[i].rdy);
      chk($sformatf("tbl%0d_hsync", i), o.hsync, vecs[i].hs);
      chk($sformatf("tbl%0d_row", i), o.row, vecs[i].row);
      chk($sformatf("tbl%0d_col", i), o.col, vecs[i].col);
      chk($sformatf("tbl%0d_fd", i), o.frame_done, 0);
    end
    chk("tbl_reset_data", get_obs(0).data, 0);
    HRESET = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    @(posedge HCLK); #1;

    run_frame(0, 0, 2);
    run_frame(0, 1, 2);
    for (int n = 0; n < 3; n++) run_frame(0, 2, 2);
    run_frame(0, 3, 2);
    run_frame(0, 4, 2);
    run_frame(0, 0, 2);
    run_frame(1, 0, 0);
    run_frame(1, 1, 0);
    run_frame(1, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/image_write_ctrl.md
# image_write_ctrl

Frame scheduler sitting between the colour-processing pipeline and the BMP image writer. Accepts RGB pixel pairs (odd/even) from upstream over a valid/ready handshake and buffers them in a small FIFO. Drives the writer's `hsync` and `DATA_WRITE_*` inputs at one pair per cycle, inserts a programmable blanking gap after each row, and signals end of frame. The writer sees exactly WIDTH*HEIGHT/2 `hsync` beats per frame, grouped in rows of WIDTH/2.

## Interface
- `WIDTH`, 768: pixels per row; must be even.
- `HEIGHT`, 512: rows per frame.
- `HBLANK`, 4: idle cycles (`hsync`=0) forced after every row except the last; 0 allowed.
- `FIFO_DEPTH`, 4: entries in input buffer; power of two, ≥2.

Ports:
- `HCLK` in 1: clock; all logic on rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a frame; honoured only in IDLE.
- `in_valid` in 1: upstream pair valid.
- `in_ready` out 1: controller can accept a pair.
- `in_pixels` in 48: {R0,G0,B0,R1,G1,B1}, 8 bits each, R0 at [47:40]; pixel 0 (odd) is written first.
- `hsync` out 1: write strobe to image writer.
- `DATA_WRITE_R0`, `DATA_WRITE_G0`, `DATA_WRITE_B0`, `DATA_WRITE_R1`, `DATA_WRITE_G1`, `DATA_WRITE_B1` out 8 each: pair presented with `hsync`.
- `busy` out 1: high in ACTIVE, BLANK and DONE.
- `row` out clog2(HEIGHT): row of the next pair to be emitted.
- `col` out clog2(WIDTH/2): pair index within row of the next pair to be emitted.
- `frame_done` out 1: one-cycle pulse after the final pair of the frame.

## Operation
- States: IDLE, ACTIVE, BLANK, DONE.
- IDLE:
  - `start` → ACTIVE.
  - Clear `row`, `col`, the accept counter and the emit counter.
  - FIFO is empty here by construction.
- Acceptance:
  - `in_ready` = (state ACTIVE or BLANK) and FIFO not full and accept counter < WIDTH*HEIGHT/2.
  - A beat is taken when `in_valid` && `in_ready`; the accept counter then increments.
  - The controller never accepts more than one frame of pairs.
- ACTIVE, FIFO non-empty:
  - Pop one entry; the registered outputs present it next cycle with `hsync`=1.
  - Advance `col`.
  - On the pop with `col`=WIDTH/2-1: set `col` to 0.
    - If `row`=HEIGHT-1 → DONE.
    - Else `row`+1, and → BLANK if HBLANK>0, otherwise stay in ACTIVE.
- ACTIVE, FIFO empty (underrun): no pop, `hsync`=0, counters hold. Stalls are legal and unbounded.
- BLANK:
  - Counter runs HBLANK cycles with no pop, then → ACTIVE.
  - FIFO keeps accepting during BLANK.
- DONE: assert `frame_done` for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored.
- Simultaneous push and pop on a full FIFO is allowed. `in_ready` uses the registered full flag, so no push occurs that cycle when the FIFO is full; no overflow is possible.
- `DATA_WRITE_*` holds its last value while `hsync`=0.
- Emit counter reaches WIDTH*HEIGHT/2 exactly when entering DONE. Counter widths are sized with $clog2; no wrap within a frame.

## Timing
- Reset values:
  - Outputs `hsync`, `in_ready`, `busy`, `frame_done`, `row`, `col` and all `DATA_WRITE_*` = 0.
  - Internal: state = IDLE, FIFO empty, all counters 0.
- `HRESET` mid-frame discards FIFO contents and counters on the next edge; no partial-frame `frame_done` is produced.
- `start` sampled at edge t → `busy`=1 and `in_ready`=1 from t+1.
- Latency: beat accepted at edge t into an empty FIFO → popped at t+1 → `hsync`=1 with that data during cycle after t+1. Minimum 2 cycles.
- Throughput: one pair per cycle sustained within a row when upstream holds `in_valid`=1.
- Row gap: the last `hsync` of row r is followed by exactly HBLANK cycles of `hsync`=0 before the first `hsync` of row r+1, absent underrun.
- Final pair: its `hsync` cycle is followed immediately by the `frame_done` pulse; `busy` falls in the cycle after `frame_done`.

## Test plan
- Use WIDTH=8, HEIGHT=4, HBLANK=2, FIFO_DEPTH=4 unless noted.
- Continuous input: `start`, then `in_valid`=1 with an incrementing pattern → 16 `hsync` beats in 4 bursts of 4, each gap exactly 2 cycles. Data order and byte lanes match input. `frame_done` pulses once, 1 cycle after the 16th beat.
- Backpressure: `in_valid` held 1 while the FIFO fills during BLANK → `in_ready` drops at 4 entries. No pair is lost or duplicated, and `in_ready`=0 after the 16th accept.
- Underrun: `in_valid` toggles 1/0 each cycle → `hsync` gaps appear mid-row, `col` holds during the gaps, output sequence is unchanged, and `row`/`col` stay consistent.
- HBLANK=0: `in_valid`=1 continuously → 16 consecutive `hsync` cycles with no gaps.
- Reset mid-frame: assert `HRESET` after the 6th beat → all outputs 0 next cycle and `in_ready`=0. A new `start` then produces a full 16-beat frame.
- `start` re-pulsed during ACTIVE is ignored; the frame completes normally with exactly one `frame_done`.
